// File: rtl/axi4_if.sv
// axi4_if: AXI4 read-address and read-data channels; master drives AR fields and rready, slave drives arready and R fields
interface axi4_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [2:0]            arsize;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;
  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/icache_refill.sv
// icache_refill: AXI4 read master that fills one cache line per request; req_* accepts a line address, resp_* returns line/addr/err, mem_if drives AR and R-ready
module icache_refill #(
  parameter int LINE_WORDS = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic [ADDR_WIDTH-1:0]            req_addr,
  output logic                             resp_valid,
  input  logic                             resp_ready,
  output logic [ADDR_WIDTH-1:0]            resp_addr,
  output logic [LINE_WORDS*DATA_WIDTH-1:0] resp_line,
  output logic                             resp_err,
  axi4_if.master                           mem_if
);
  localparam int IW = $clog2(LINE_WORDS);
  localparam int CW = IW + 1;
  typedef enum logic [1:0] {IDLE, AR, R, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] line_q, line_d;
  logic err_q, err_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic req_ready_q, arvalid_q, rready_q, resp_valid_q;
  logic beat, in_range;
  assign beat     = mem_if.rvalid & rready_q;
  assign in_range = cnt_q < CW'(LINE_WORDS);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    err_d   = err_q;
    base_d  = base_q;
    case (state_q)
      IDLE: if (req_valid) begin
        state_d = AR;
        base_d  = req_addr & ~ADDR_WIDTH'(LINE_WORDS * 4 - 1);
        cnt_d   = '0;
        err_d   = 1'b0;
      end
      AR: state_d = mem_if.arready ? R : AR;
      R: if (beat) begin
        if (in_range) line_d[cnt_q[IW-1:0]] = mem_if.rdata;
        cnt_d   = cnt_q + CW'(in_range);
        err_d   = err_q | (mem_if.rresp != 2'b00) | !in_range
                | (mem_if.rlast & (cnt_q != CW'(LINE_WORDS - 1)));
        state_d = mem_if.rlast ? DONE : R;
      end
      DONE: state_d = resp_ready ? IDLE : DONE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      line_q       <= '0;
      err_q        <= 1'b0;
      base_q       <= '0;
      req_ready_q  <= 1'b1;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      resp_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      err_q        <= err_d;
      base_q       <= base_d;
      req_ready_q  <= state_d == IDLE;
      arvalid_q    <= state_d == AR;
      rready_q     <= state_d == R;
      resp_valid_q <= state_d == DONE;
    end
  end
  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_addr      = base_q;
  assign resp_line      = line_q;
  assign resp_err       = err_q;
  assign mem_if.araddr  = base_q;
  assign mem_if.arlen   = 8'(LINE_WORDS - 1);
  assign mem_if.arsize  = 3'd2;
  assign mem_if.arburst = 2'b01;
  assign mem_if.arvalid = arvalid_q;
  assign mem_if.rready  = rready_q;
endmodule

// File: tb/tb_icache_refill.sv
// tb_icache_refill: directed checks of icache_refill against a procedural AXI4 read slave
module tb_icache_refill;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0;
  logic resp_ready = 1'b0;
  logic [31:0] req_addr = '0;
  logic req_ready, resp_valid, resp_err;
  logic [31:0] resp_addr;
  logic [127:0] resp_line;
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  localparam logic [127:0] LINE = 128'h00000044_00000033_00000022_00000011;
  localparam logic [127:0] ALL  = {128{1'b1}};
  localparam logic [127:0] LOW2 = {64'h0, {64{1'b1}}};
  axi4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) mem_if ();
  icache_refill #(.LINE_WORDS(4), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_addr(resp_addr),
    .resp_line(resp_line),
    .resp_err(resp_err),
    .mem_if(mem_if)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic refill(input logic [31:0] addr, input int stall, input logic [3:0] gap,
                        input int nb, input int err_at, input int hold,
                        input logic [127:0] mask, input logic exp_err);
    int c0, n, gaps;
    @(negedge clk);
    chk("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1;
    req_addr  = addr;
    c0 = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (!mem_if.arvalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("ar_wait", n < 20, 1'b1);
    for (int i = 0; i <= stall; i++) begin
      chk("arvalid", mem_if.arvalid, 1'b1);
      chk("araddr", mem_if.araddr, addr & 32'hFFFF_FFF0);
      chk("arlen", mem_if.arlen, 8'd3);
      chk("arsize", mem_if.arsize, 3'd2);
      chk("arburst", mem_if.arburst, 2'b01);
      chk("req_ready_busy", req_ready, 1'b0);
      mem_if.arready = (i == stall);
      @(negedge clk);
    end
    mem_if.arready = 1'b0;
    gaps = 0;
    for (int i = 0; i < nb; i++) begin
      if (gap[i]) begin
        mem_if.rvalid = 1'b0;
        gaps++;
        @(negedge clk);
      end
      chk("rready", mem_if.rready, 1'b1);
      chk("arvalid_in_r", mem_if.arvalid, 1'b0);
      chk("resp_early", resp_valid, 1'b0);
      mem_if.rvalid = 1'b1;
      mem_if.rdata  = 32'h11 * (i + 1);
      mem_if.rresp  = (i == err_at) ? 2'b10 : 2'b00;
      mem_if.rlast  = (i == nb - 1);
      @(negedge clk);
    end
    mem_if.rvalid = 1'b0;
    mem_if.rlast  = 1'b0;
    mem_if.rresp  = 2'b00;
    chk("resp_cycle", cyc - c0, 2 + stall + gaps + nb);
    for (int k = 0; k <= hold; k++) begin
      chk("resp_valid", resp_valid, 1'b1);
      chk("resp_line", resp_line & mask, LINE & mask);
      chk("resp_addr", resp_addr, addr & 32'hFFFF_FFF0);
      chk("resp_err", resp_err, exp_err);
      chk("req_ready_done", req_ready, 1'b0);
      chk("rready_done", mem_if.rready, 1'b0);
      req_valid  = (k < hold) && (k % 2 == 0);
      req_addr   = 32'h1234_5000;
      resp_ready = (k == hold);
      @(negedge clk);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    chk("idle_resp_valid", resp_valid, 1'b0);
    chk("idle_req_ready", req_ready, 1'b1);
    chk("idle_arvalid", mem_if.arvalid, 1'b0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    mem_if.arready = 1'b0;
    mem_if.rvalid  = 1'b0;
    mem_if.rdata   = '0;
    mem_if.rresp   = 2'b00;
    mem_if.rlast   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_arvalid", mem_if.arvalid, 1'b0);
    chk("rst_rready", mem_if.rready, 1'b0);
    chk("rst_resp_valid", resp_valid, 1'b0);
    chk("rst_resp_err", resp_err, 1'b0);
    chk("rst_resp_addr", resp_addr, 32'h0);
    chk("rst_resp_line", resp_line, 128'h0);
    reset = 1'b0;
    refill(32'h8000_0014, 0, 4'b0000, 4, -1, 0, ALL, 1'b0);
    refill(32'h8000_0018, 3, 4'b1010, 4, -1, 0, ALL, 1'b0);
    refill(32'h8000_0010, 0, 4'b0000, 4, -1, 5, ALL, 1'b0);
    refill(32'h8000_0014, 0, 4'b0000, 2, -1, 0, LOW2, 1'b1);
    refill(32'h8000_001C, 0, 4'b0000, 4, 2, 0, ALL, 1'b1);
    refill(32'h8000_0014, 0, 4'b0000, 4, -1, 0, ALL, 1'b0);
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 32'h8000_0024;
    @(negedge clk);
    req_valid = 1'b0;
    mem_if.arready = 1'b1;
    @(negedge clk);
    mem_if.arready = 1'b0;
    chk("mid_rready", mem_if.rready, 1'b1);
    mem_if.rvalid = 1'b1;
    mem_if.rdata  = 32'h11;
    @(negedge clk);
    mem_if.rdata = 32'h22;
    reset = 1'b1;
    #1;
    chk("mid_rst_arvalid", mem_if.arvalid, 1'b0);
    chk("mid_rst_rready", mem_if.rready, 1'b0);
    chk("mid_rst_resp_valid", resp_valid, 1'b0);
    chk("mid_rst_req_ready", req_ready, 1'b1);
    chk("mid_rst_line", resp_line, 128'h0);
    mem_if.rvalid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    refill(32'h8000_0024, 0, 4'b0000, 4, -1, 0, ALL, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/icache_refill.md
Name: icache_refill

Overview:
- AXI4 read master that fills one instruction-cache line per request from the simulation memory slave.
- Accepts a line-refill request from the fetch/cache side and issues a single INCR burst read on the AXI4 read channels.
- Assembles the returned beats into a line buffer and hands the completed line back with a valid/ready handshake.
- Sits directly upstream of the memory slave and drives its AR channel and R-channel ready.

Parameters:
- LINE_WORDS, 4, 32-bit words per cache line. Power of two, 2..16.
- DATA_WIDTH, 32, AXI data width and word width. Fixed at 32 for this block.
- ADDR_WIDTH, 32, request and AXI address width.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  refill request valid.
- req_ready  output  1  block can accept a request.
- req_addr  input  ADDR_WIDTH  any byte address inside the wanted line.
- resp_valid  output  1  line complete and held stable.
- resp_ready  input  1  consumer accepts the line.
- resp_addr  output  ADDR_WIDTH  line-aligned base address of the returned line.
- resp_line  output  LINE_WORDS*DATA_WIDTH  line data; word i is at bits [32i+31:32i], word 0 at the base address.
- resp_err  output  1  line is corrupt (bad rresp or beat-count mismatch).
- mem_if  interface  -  axi4_if.master modport.
  - Drives araddr, arlen, arsize, arburst, arvalid, rready.
  - Samples arready, rdata, rresp, rlast, rvalid.

Behaviour:
- States: IDLE, AR, R, DONE.
- Reset (asynchronous, any state, including mid-burst):
  - state=IDLE, beat counter=0, line buffer=0, err=0, base=0.
  - Outputs: req_ready=1, arvalid=0, rready=0, resp_valid=0, resp_err=0.
- IDLE:
  - req_ready=1.
  - On req_valid: latch base = req_addr with low log2(LINE_WORDS*4) bits cleared; clear cnt and err; go to AR.
- AR:
  - arvalid=1, araddr=base, arlen=LINE_WORDS-1, arsize=3'd2, arburst=2'b01 (INCR).
  - Hold all AR fields stable until arready.
  - On arvalid&arready: go to R.
  - arvalid is 0 in every other state.
- R:
  - rready=1.
  - Each rvalid&rready beat:
    - If cnt<LINE_WORDS, write rdata to word[cnt].
    - cnt increments, saturating at LINE_WORDS.
    - If rresp!=0, set err (sticky).
  - Beat with rlast:
    - If cnt!=LINE_WORDS-1 (early or late last), set err.
    - Go to DONE.
  - A beat with cnt>=LINE_WORDS (slave overran arlen): data dropped, err set, keep rready=1 until rlast.
- DONE:
  - resp_valid=1; resp_line, resp_addr, resp_err stable.
  - On resp_ready: go to IDLE.
  - resp_valid without resp_ready holds indefinitely.
- Only one outstanding burst. req_ready=0 in AR/R/DONE; requests there are ignored, not queued.
- Timing with a zero-wait slave (arready=1 in IDLE, rvalid the cycle after AR handshake, one beat per cycle), request accepted in cycle 0:
  - arvalid in cycle 1, AR handshake in cycle 1.
  - Beats in cycles 2..1+LINE_WORDS.
  - resp_valid from cycle 2+LINE_WORDS.
- Back-to-back: a new request may be accepted the cycle after the DONE handshake (state is IDLE).
- Address arithmetic: base + LINE_WORDS*4 must not cross a 4 KB boundary; guaranteed by alignment, no check needed.

Test Plan:
- Reset, then req_addr=0x8000_0014, LINE_WORDS=4, memory words 0x11,0x22,0x33,0x44 at 0x8000_0010..1C:
  - araddr=0x8000_0010, arlen=3, arsize=2, arburst=1.
  - resp_line={0x44,0x33,0x22,0x11}, resp_addr=0x8000_0010, resp_err=0.
  - resp_valid in cycle 6.
- Slave stalls arready 3 cycles and inserts rvalid gaps:
  - araddr/arlen stable throughout the stall.
  - Same line data; resp_valid only after the 4th beat.
- Hold resp_ready=0 for 5 cycles in DONE:
  - resp_valid, resp_line, resp_addr constant.
  - req_valid pulses ignored (req_ready=0).
  - After resp_ready, IDLE next cycle.
- Slave asserts rlast on beat 2 of 4 -> resp_err=1, DONE reached after beat 2, words 0-1 valid.
- rresp=2'b10 on beat 3 -> resp_err=1, all 4 words still captured.
- Assert reset mid-R after beat 1:
  - Immediately arvalid=0, rready=0, resp_valid=0, req_ready=1.
  - After release, a fresh request completes correctly.
